// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN datapath constants and width helpers
// used by the word-slice select mux and the byte/word packer.
package cnn_pkg;

    localparam int OUT_D_W = 128;
    localparam int S_W     = 4;

    function automatic int byte_width(input int out_d_w, input int s_w);
        return out_d_w / (2 ** s_w);
    endfunction

    function automatic int ilog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((32'sd1 <<< i) <= v) r = i;
        return r;
    endfunction

endpackage

// File: rtl/slot_demux.sv
// slot_demux: returns word with byte slot `slot` replaced by `data`;
// slot 0 occupies the LSBs, the same slicing as the select mux.
module slot_demux
    import cnn_pkg::*;
#(
    parameter int Out_d_W = OUT_D_W,
    parameter int S_W     = cnn_pkg::S_W,
    localparam int B      = byte_width(Out_d_W, S_W)
) (
    input  logic [Out_d_W-1:0] word,
    input  logic [S_W-1:0]     slot,
    input  logic [B-1:0]       data,
    output logic [Out_d_W-1:0] result
);

    always_comb begin
        result = word;
        result[int'(slot)*B +: B] = data;
    end

endmodule

// File: rtl/byte_word_packer.sv
// byte_word_packer: serial-to-parallel packer, 2**S_W bytes per word, valid/ready on both sides.
// Define BYTE_WORD_PACKER_FLUSH_EN to let in_last emit a zero-padded partial word.
module byte_word_packer
    import cnn_pkg::*;
#(
    parameter int Out_d_W = OUT_D_W,
    parameter int S_W     = cnn_pkg::S_W,
    localparam int N      = 2 ** S_W,
    localparam int B      = byte_width(Out_d_W, S_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [B-1:0]       in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    output logic [Out_d_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [S_W:0]       out_bytes,
    output logic [S_W-1:0]     slot_idx
);

    logic [S_W-1:0]     cnt;
    logic [Out_d_W-1:0] acc;
    logic [Out_d_W-1:0] merged;
    logic               flush_term;
    logic               term;
    logic               in_fire;
    logic               out_fire;
    logic               complete;

`ifdef BYTE_WORD_PACKER_FLUSH_EN
    assign flush_term = in_last;
`else
    logic unused_last;
    assign unused_last = in_last;
    assign flush_term  = 1'b0;
`endif

    // Only the word-completing byte has to wait for a free output register.
    assign term     = (cnt == S_W'(N - 1)) | flush_term;
    assign in_ready = !out_valid | out_ready | !term;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign complete = in_fire & term;
    assign slot_idx = cnt;

    slot_demux #(
        .Out_d_W (Out_d_W),
        .S_W     (S_W)
    ) u_slot_demux (
        .word   (acc),
        .slot   (cnt),
        .data   (in_data),
        .result (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_bytes <= '0;
        end else begin
            if (complete) begin
                out_data  <= merged;
                out_bytes <= (S_W+1)'(cnt) + (S_W+1)'(1);
                acc       <= '0;
                cnt       <= '0;
            end else if (in_fire) begin
                acc <= merged;
                cnt <= cnt + S_W'(1);
            end
            out_valid <= complete ? 1'b1 : (out_fire ? 1'b0 : out_valid);
        end
    end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Serial-to-parallel packer. Accepts one Out_d_W/2**S_W-bit byte per handshake and assembles 2**S_W bytes into one Out_d_W-bit word.
- It is the write-side counterpart of the word-slice select mux. Byte slot i maps to word bits [i*B+B-1 : i*B], so slot 0 occupies the LSBs.
- Sits between byte-wide producers (pixel/weight loaders) and wide-word consumers (line buffers, PE arrays).
- Uses valid/ready on both sides and sustains full throughput of one byte per cycle.

Parameters:
- Out_d_W, 128, width of the assembled output word.
- S_W, 4, slot-index width. Slot count N = 2**S_W. Byte width B = Out_d_W/N, default 8. Out_d_W must be divisible by N.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  B  input byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  packer can accept a byte this cycle.
- in_last  input  1  final byte of a burst; only functional with the flush feature.
- out_data  output  Out_d_W  assembled word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_bytes  output  S_W+1  number of valid bytes in out_data, range 1..N.
- slot_idx  output  S_W  slot the next accepted byte will be written to (debug/status).

Behaviour:
- Reset (async assert, sync release):
  - cnt=0, acc=0, out_data=0, out_valid=0, out_bytes=0, slot_idx=0.
  - in_ready reads 1 after reset.
  - Asserting reset mid-word discards the partial word and any held output word.
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - complete = in_fire & (cnt==N-1 | flush_term), where flush_term = in_last with the feature, else 0.
- in_ready = !out_valid | out_ready | !(cnt==N-1 | flush_term). Backpressure applies only to the byte that completes a word while the output register is still occupied and not draining.
- in_fire and not complete:
  - acc slot cnt <= in_data.
  - cnt <= cnt+1.
- complete:
  - out_data <= acc with slot cnt replaced by in_data.
  - out_bytes <= cnt+1.
  - out_valid <= 1.
  - acc <= 0, cnt <= 0 (wrap).
- Latency: the completing byte is accepted in cycle t; out_valid and out_data are visible in cycle t+1.
- out_fire without complete in the same cycle: out_valid <= 0. out_data and out_bytes hold their last values.
- out_fire and complete in the same cycle: the new word loads and out_valid stays 1, giving no bubble.
- out_data and out_bytes must be stable while out_valid=1 and out_ready=0.
- Bytes for the next word may be accepted into acc while an output word is still waiting, up to slot N-2 (or up to a non-last byte).
- Unwritten slots of a partial word are guaranteed 0, because acc is cleared on every complete.
- slot_idx = cnt.
- No internal state machine beyond cnt and out_valid. The effective states are FILL and FILL+HOLD, where HOLD means out_valid=1.

Optional Feature:
- Macro: BYTE_WORD_PACKER_FLUSH_EN.
- Defined:
  - in_last terminates the word early. A partial word is emitted with out_bytes=cnt+1 and zero upper slots.
  - in_last on slot N-1 behaves like a normal full word.
- Undefined:
  - in_last is ignored and flush_term is tied to 0.
  - out_bytes equals N after the first word, and is 0 before any word.

Decomposition:
- Shared package cnn_pkg holds:
  - Default constants OUT_D_W=128, S_W=4.
  - A derived-byte-width function Out_d_W/2**S_W.
  - An ilog2 helper shared with the select mux.
- One natural sub-module, slot_demux: combinational. It takes word, slot index and byte, and returns the word with that slot replaced. It is the inverse of the select mux and uses the same slicing. The packer instantiates it on acc.

Test Plan:
- Full word: 16 bytes 0x00..0x0F back-to-back, out_ready=1 -> out_data=0x0F0E0D0C0B0A09080706050403020100 and out_bytes=16 one cycle after the 16th accept; in_ready never drops.
- Streaming: 48 bytes, in_valid=1 throughout, out_ready=1 -> exactly 3 words, with out_valid high on consecutive word boundaries and no lost or duplicated bytes.
- Backpressure: hold out_ready=0 after word 1 and keep sending -> 15 bytes accepted, then in_ready=0 at cnt=15. Raise out_ready -> word 1 drains and the 16th byte is accepted in the same cycle, so word 2 is valid the next cycle.
- Flush (feature on): bytes AA, BB, CC with in_last on CC -> out_data=0x...00CCBBAA with the upper 13 slots 0 and out_bytes=3. The next burst starts at slot 0. With the feature off, the same stimulus gives no output until 13 more bytes arrive.
- Async reset mid-word: 5 bytes accepted, rst_n pulsed low between clock edges -> out_valid=0, slot_idx=0 immediately. The next 16 bytes 0x10..0x1F give a word containing only those bytes.
- Slot mapping: a single 0xFF at slot k (zeros elsewhere) for k = 0, 7, 15 -> the select mux with S=k on out_data returns 0xFF and all other S values return 0.
